// File: rtl/mdu_sched_pkg.sv
// Shared MDU definitions: op codes, default latencies and FSM state encoding.
package mdu_sched_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

    // Codes 9-15 behave exactly like "no operation".
    function automatic logic [3:0] mdu_norm_op(input logic [3:0] op);
        return (op > MDU_MTLO) ? MDU_NONE : op;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the pending HI/LO pair.
// MDU_DIV0_KEEP_EN: divide by zero returns the current HI/LO instead of a fixed result.
module mdu_arith
    import mdu_sched_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
`ifdef MDU_DIV0_KEEP_EN
    input  logic [31:0] hi_cur,
    input  logic [31:0] lo_cur,
`endif
    output logic [31:0] hi_p,
    output logic [31:0] lo_p
);

    logic signed [63:0] rs_x;
    logic signed [63:0] rt_x;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] rt_safe;
    logic        [31:0] rs_mag;
    logic        [31:0] rt_mag;
    logic        [31:0] q_mag;
    logic        [31:0] r_mag;
    logic        [31:0] q_u;
    logic        [31:0] r_u;
    logic        [31:0] q_s;
    logic        [31:0] r_s;
    logic               rt_zero;

    always_comb begin
        rs_x    = {{32{rs[31]}}, rs};
        rt_x    = {{32{rt[31]}}, rt};
        prod_s  = rs_x * rt_x;
        prod_u  = {32'd0, rs} * {32'd0, rt};
        rt_zero = (rt == 32'd0);
        // A zero divisor is swapped for 1 so no X ever leaves the divider.
        rt_safe = rt_zero ? 32'd1 : rt;
        q_u     = rs / rt_safe;
        r_u     = rs % rt_safe;
        // Signed divide on magnitudes avoids the INT_MIN / -1 overflow trap.
        rs_mag  = rs[31] ? (~rs + 32'd1) : rs;
        rt_mag  = rt[31] ? (~rt_safe + 32'd1) : rt_safe;
        q_mag   = rs_mag / rt_mag;
        r_mag   = rs_mag % rt_mag;
        q_s     = (rs[31] ^ rt[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s     = rs[31] ? (~r_mag + 32'd1) : r_mag;

        hi_p = 32'd0;
        lo_p = 32'd0;
        case (op)
            MDU_MULT:  {hi_p, lo_p} = prod_s;
            MDU_MULTU: {hi_p, lo_p} = prod_u;
            MDU_DIV, MDU_DIVU: begin
                if (rt_zero) begin
`ifdef MDU_DIV0_KEEP_EN
                    hi_p = hi_cur;
                    lo_p = lo_cur;
`else
                    hi_p = rs;
                    lo_p = (op == MDU_DIVU || !rs[31]) ? 32'hFFFF_FFFF : 32'h0000_0001;
`endif
                end else if (op == MDU_DIV) begin
                    hi_p = r_s;
                    lo_p = q_s;
                end else begin
                    hi_p = r_u;
                    lo_p = q_u;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_sched.sv
// Multi-cycle MDU scheduler: IDLE/BUSY FSM, latency counter, HI/LO and stall request.
// MDU_DIV0_KEEP_EN selects whether divide by zero keeps HI/LO unchanged.
module mdu_sched
    import mdu_sched_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp_E,
    input  logic [3:0]  MDUOp_D,
    input  logic [31:0] rsData_E,
    input  logic [31:0] rtData_E,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut_E,
    output logic        Stall_MDU
);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_p_q, hi_p_d;
    logic [31:0] lo_p_q, lo_p_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] arith_hi, arith_lo;
    logic [3:0]  op_e, op_d;
    logic        is_muldiv, is_mult;

    mdu_arith u_arith (
        .op     (op_e),
        .rs     (rsData_E),
        .rt     (rtData_E),
`ifdef MDU_DIV0_KEEP_EN
        .hi_cur (hi_q),
        .lo_cur (lo_q),
`endif
        .hi_p   (arith_hi),
        .lo_p   (arith_lo)
    );

    always_comb begin
        op_e      = mdu_norm_op(MDUOp_E);
        op_d      = mdu_norm_op(MDUOp_D);
        is_muldiv = (op_e >= MDU_MULT) && (op_e <= MDU_DIVU);
        is_mult   = (op_e == MDU_MULT) || (op_e == MDU_MULTU);
        Start     = is_muldiv && (state_q == ST_IDLE);
        Busy      = (state_q == ST_BUSY);
        Stall_MDU = (op_d != MDU_NONE) && (Start || Busy);
        HI        = hi_q;
        LO        = lo_q;
        case (op_e)
            MDU_MFHI: MDUOut_E = hi_q;
            MDU_MFLO: MDUOut_E = lo_q;
            default:  MDUOut_E = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_p_d  = hi_p_q;
        lo_p_d  = lo_p_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == ST_IDLE) begin
            if (Start) begin
                hi_p_d  = arith_hi;
                lo_p_d  = arith_lo;
                cnt_d   = is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                state_d = ST_BUSY;
            end else if (op_e == MDU_MTHI) begin
                hi_d = rsData_E;
            end else if (op_e == MDU_MTLO) begin
                lo_d = rsData_E;
            end
        end else begin
            // Any op in E while busy is ignored; only the countdown advances.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                hi_d    = hi_p_q;
                lo_d    = lo_p_q;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            hi_p_q  <= 32'd0;
            lo_p_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_p_q  <= hi_p_d;
            lo_p_q  <= lo_p_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed cases plus randomized ops against a reference model.
module tb_mdu_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  MDUOp_E;
    logic [3:0]  MDUOp_D;
    logic [31:0] rsData_E;
    logic [31:0] rtData_E;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut_E;
    logic        Stall_MDU;

    int          n_vec;
    int          n_err;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    mdu_sched dut (
        .clk       (clk),
        .reset     (reset),
        .MDUOp_E   (MDUOp_E),
        .MDUOp_D   (MDUOp_D),
        .rsData_E  (rsData_E),
        .rtData_E  (rtData_E),
        .Start     (Start),
        .Busy      (Busy),
        .HI        (HI),
        .LO        (LO),
        .MDUOut_E  (MDUOut_E),
        .Stall_MDU (Stall_MDU)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result {HI,LO} from the architectural definition of each op.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [31:0] hi_o,
                                          input logic [31:0] lo_o);
        longint a, b, q, r;
        int     sa, sb;
        logic [63:0] res;
        res = {hi_o, lo_o};
        sa = rs;
        sb = rt;
        case (op)
            4'd1: begin a = sa; b = sb; q = a * b; res = q; end
            4'd2: begin a = longint'({32'd0, rs}); b = longint'({32'd0, rt}); q = a * b; res = q; end
            4'd3, 4'd4: begin
                if (rt == 32'd0) begin
`ifdef MDU_DIV0_KEEP_EN
                    res = {hi_o, lo_o};
`else
                    res = {rs, (op == 4'd4 || sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001};
`endif
                end else begin
                    if (op == 4'd3) begin a = sa; b = sb; end
                    else begin a = longint'({32'd0, rs}); b = longint'({32'd0, rt}); end
                    q = a / b;
                    r = a % b;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: ;
        endcase
        return res;
    endfunction

    // Issue a mul/div in E with dop waiting in D; optionally push ignored ops in while busy.
    task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [3:0] dop, input bit intrude);
        int          n;
        logic [63:0] exp;
        n   = (op <= 4'd2) ? 5 : 10;
        exp = model(op, rs, rt, hi_m, lo_m);
        MDUOp_E  = op;
        MDUOp_D  = dop;
        rsData_E = rs;
        rtData_E = rt;
        #1;
        chk("start", 32'(Start), 32'd1);
        chk("stall_t", 32'(Stall_MDU), 32'(dop != 4'd0));
        tick();
        for (int i = 1; i <= n; i++) begin
            MDUOp_E  = 4'd0;
            rsData_E = $urandom;
            rtData_E = $urandom;
            if (intrude && i == 2) begin MDUOp_E = 4'd7; rsData_E = 32'hDEAD_BEEF; end
            if (intrude && i == 3) MDUOp_E = 4'd3;
            if (intrude && i == 4) begin MDUOp_E = 4'd8; rsData_E = 32'hCAFE_F00D; end
            #1;
            chk("busy_on", 32'(Busy), 32'd1);
            chk("start_busy", 32'(Start), 32'd0);
            chk("stall_busy", 32'(Stall_MDU), 32'(dop != 4'd0));
            chk("hi_hold", HI, hi_m);
            chk("lo_hold", LO, lo_m);
            tick();
        end
        {hi_m, lo_m} = exp;
        MDUOp_E = 4'd0;
        MDUOp_D = 4'd0;
        #1;
        chk("busy_off", 32'(Busy), 32'd0);
        chk("hi_commit", HI, hi_m);
        chk("lo_commit", LO, lo_m);
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] rs);
        MDUOp_E  = op;
        MDUOp_D  = 4'd0;
        rsData_E = rs;
        #1;
        chk("mt_start", 32'(Start), 32'd0);
        tick();
        if (op == 4'd7) hi_m = rs;
        else lo_m = rs;
        MDUOp_E = 4'd0;
        #1;
        chk("mt_hi", HI, hi_m);
        chk("mt_lo", LO, lo_m);
    endtask

    task automatic read_back();
        MDUOp_E = 4'd5;
        #1;
        chk("mfhi", MDUOut_E, hi_m);
        MDUOp_E = 4'd6;
        #1;
        chk("mflo", MDUOut_E, lo_m);
        MDUOp_E = 4'd0;
        #1;
        chk("mdu_out_none", MDUOut_E, 32'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [3:0]  dop;
        logic [31:0] rs;
        logic [31:0] rt;
        n_vec    = 0;
        n_err    = 0;
        hi_m     = 32'd0;
        lo_m     = 32'd0;
        reset    = 1'b1;
        MDUOp_E  = 4'd0;
        MDUOp_D  = 4'd0;
        rsData_E = 32'd0;
        rtData_E = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_start", 32'(Start), 32'd0);
        chk("rst_out", MDUOut_E, 32'd0);
        chk("rst_stall", 32'(Stall_MDU), 32'd0);
        tick();

        // mult -2*3 with mflo waiting in D; mflo then reads the new LO.
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 4'd6, 1'b0);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA);
        MDUOp_E = 4'd6;
        #1;
        chk("mflo_after_stall", MDUOut_E, 32'hFFFF_FFFA);
        chk("stall_released", 32'(Stall_MDU), 32'd0);
        MDUOp_E = 4'd0;
        tick();

        run_op(4'd4, 32'd7, 32'd2, 4'd0, 1'b0);
        chk("divu_lo", LO, 32'd3);
        chk("divu_hi", HI, 32'd1);
        tick();
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 4'd5, 1'b0);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);
        tick();

        move_to(4'd7, 32'h1234_5678);
        MDUOp_E = 4'd5;
        #1;
        chk("mfhi_direct", MDUOut_E, 32'h1234_5678);
        MDUOp_E = 4'd0;
        tick();

        // mthi/div/mtlo during BUSY are dropped; latency is not restarted.
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, 1'b1);
        chk("multu_hi", HI, 32'hFFFF_FFFE);
        chk("multu_lo", LO, 32'h0000_0001);
        tick();

        run_op(4'd3, 32'd5, 32'd0, 4'd0, 1'b0);
`ifdef MDU_DIV0_KEEP_EN
        chk("div0_hi", HI, 32'hFFFF_FFFE);
        chk("div0_lo", LO, 32'h0000_0001);
`else
        chk("div0_hi", HI, 32'd5);
        chk("div0_lo", LO, 32'hFFFF_FFFF);
`endif
        tick();

        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'd0, 1'b0);
        tick();

        // Reset during the third busy cycle of a div discards the result.
        MDUOp_E  = 4'd3;
        rsData_E = 32'd1000;
        rtData_E = 32'd7;
        tick();
        MDUOp_E = 4'd0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("busy_pre_rst", 32'(Busy), 32'd1);
        tick();
        reset = 1'b0;
        hi_m  = 32'd0;
        lo_m  = 32'd0;
        #1;
        chk("midrst_busy", 32'(Busy), 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("midrst_no_commit_hi", HI, 32'd0);
        chk("midrst_no_commit_lo", LO, 32'd0);
        chk("midrst_idle", 32'(Busy), 32'd0);

        for (int k = 0; k < 24; k++) begin
            op = 4'($urandom_range(1, 6));
            rs = $urandom;
            rt = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 5) == 0) rt = 32'd0;
            if (op <= 4'd4) begin
                dop = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                if (dop > 4'd8) dop = 4'd0;
                run_op(op, rs, rt, dop, 1'b0);
            end else begin
                move_to((op == 4'd5) ? 4'd7 : 4'd8, rs);
            end
            read_back();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_sched.md
# mdu_sched

Multi-cycle multiply/divide scheduler for the five-stage MIPS core. It sits in the EX stage beside the ALU and consumes the `MDUOp` code decoded from the ID/EX register. It sequences `mult`/`multu`/`div`/`divu` over a fixed cycle count, owns the HI/LO registers and serves `mfhi`/`mflo`/`mthi`/`mtlo`. It also produces the stall request the hazard unit uses to hold any MDU instruction in D while the unit is occupied.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult` and `multu`; legal range 1–15.
- `DIV_CYCLES`, default 10: busy cycles for `div` and `divu`; legal range 1–15.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `MDUOp_E`, input, 4: op of the instruction in E. Encoding: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo. Codes 9–15 are treated as 0.
- `MDUOp_D`, input, 4: op of the instruction in D, same encoding; used only for the stall request.
- `rsData_E`, input, 32: forwarded rs operand.
- `rtData_E`, input, 32: forwarded rt operand.
- `Start`, output, 1: combinational; high when `MDUOp_E` is 1–4 and the unit is IDLE.
- `Busy`, output, 1: registered; high while a computation is in flight.
- `HI`, output, 32: architectural HI register.
- `LO`, output, 32: architectural LO register.
- `MDUOut_E`, output, 32: combinational. Equals `HI` for op 5, `LO` for op 6, and 0 otherwise.
- `Stall_MDU`, output, 1: combinational; equals (`MDUOp_D` != 0) && (`Start` || `Busy`).

## Operation
- Two states: IDLE and BUSY. `Busy` is 1 exactly in BUSY. A 4-bit down-counter `cnt` tracks remaining cycles.
- IDLE with `Start`:
  - Compute the result into pending registers `hi_p`/`lo_p` at the clock edge.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`, then go to BUSY.
- Arithmetic:
  - mult: signed 32×32→64; `{hi_p,lo_p}` = product.
  - multu: unsigned 32×32→64; `{hi_p,lo_p}` = product.
  - div: signed; `lo_p` = rs/rt, `hi_p` = rs%rt, both truncating toward zero, remainder takes the dividend's sign.
  - divu: unsigned; quotient and remainder as above.
- BUSY:
  - `cnt` decrements every cycle.
  - On the edge where `cnt` goes 1→0: HI←`hi_p`, LO←`lo_p`, state←IDLE.
- mthi/mtlo (ops 7 and 8): HI←rs or LO←rs at the edge, IDLE only. In BUSY they are ignored (the stall makes this unreachable).
- mfhi/mflo (ops 5 and 6): pure reads of the current HI/LO via `MDUOut_E`.
- Ops 1–4 arriving in BUSY are ignored: no restart and no counter reload. The hazard unit prevents this case.
- Reset, including mid-operation:
  - State←IDLE, `cnt`←0.
  - `hi_p`, `lo_p`, HI, LO ← 0.
  - The pending result is discarded.
- Reset values of outputs: `Busy`=0, `HI`=0, `LO`=0. `Start`, `MDUOut_E` and `Stall_MDU` are 0 whenever their inputs are 0.

## Timing
- Start in cycle t, meaning the instruction is in E during cycle t.
- `Busy` is high in cycles t+1 … t+N, where N is the configured cycle count.
- HI/LO are updated at the end of cycle t+N. They are visible from cycle t+N+1.
- Back-to-back starts:
  - A second start can be accepted in cycle t+N+1 at the earliest.
  - `Stall_MDU` holds the D-stage MDU instruction from cycle t through t+N.
  - The hazard unit inserts a bubble into E for each stalled cycle.
- Non-MDU instructions flow through E without stalling while `Busy`=1.

## Configuration
- `MDU_DIV0_KEEP_EN` defined:
  - div or divu with rt=0 still occupies the unit for `DIV_CYCLES`.
  - HI and LO keep their previous values on completion.
- `MDU_DIV0_KEEP_EN` undefined: rt=0 commits a fixed result.
  - divu: HI=rs, LO=32'hFFFF_FFFF.
  - div: HI=rs; LO=32'hFFFF_FFFF if rs ≥ 0, else 32'h0000_0001.
- In both builds no X may propagate to HI or LO.

## Structure
- The shared package holds:
  - the MDUOp code constants (`MDU_NONE` … `MDU_MTLO`);
  - the default cycle-count constants;
  - the state encoding typedef.
- One sub-module, `mdu_arith`: purely combinational. It takes op, rs and rt and produces `hi_p`/`lo_p`, including the divide-by-zero selection. `mdu_sched` keeps the FSM, counter, HI/LO and stall logic.

## Test plan
- mult, rs=32'hFFFF_FFFE (−2), rt=3 → `Busy` high for 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
- divu, rs=7, rt=2 → `Busy` high for 10 cycles; then LO=3, HI=1. div with rs=−7, rt=2 → LO=32'hFFFF_FFFD (−3), HI=32'hFFFF_FFFF (−1).
- mult in E with mflo in D → `Stall_MDU`=1 for 6 consecutive cycles; mflo then reads the new LO in cycle t+6.
- mthi with rs=32'h1234_5678 in IDLE, then mfhi → `MDUOut_E`=32'h1234_5678. An mthi in E while `Busy`=1 leaves HI unchanged.
- Reset asserted in the third `Busy` cycle of a div → the next cycle shows `Busy`=0, HI=LO=0, and the result is never committed.
- div with rt=0 and rs=5 → with `MDU_DIV0_KEEP_EN` defined, HI/LO are unchanged. Without it, HI=5 and LO=32'hFFFF_FFFF. In both builds `Busy` is high for 10 cycles.
